// File: rtl/idct_pkg.sv
// Shared definitions for the streaming 8x8 inverse DCT: cosine table,
// FSM state encoding and the rounding / saturation helpers.
package idct_pkg;

    localparam int COEF_FRAC_DEF = 12;

    // K[n][k] = round(2^12 * 0.5 * C(k) * cos((2n+1)k*pi/16)), output n, coefficient k
    localparam logic signed [15:0] K_TAB [8][8] = '{
        '{16'sd1448,  16'sd2009,  16'sd1892,  16'sd1703,  16'sd1448,  16'sd1138,  16'sd784,   16'sd400  },
        '{16'sd1448,  16'sd1703,  16'sd784,  -16'sd400,  -16'sd1448, -16'sd2009, -16'sd1892, -16'sd1138 },
        '{16'sd1448,  16'sd1138, -16'sd784,  -16'sd2009, -16'sd1448,  16'sd400,   16'sd1892,  16'sd1703 },
        '{16'sd1448,  16'sd400,  -16'sd1892, -16'sd1138,  16'sd1448,  16'sd1703, -16'sd784,  -16'sd2009 },
        '{16'sd1448, -16'sd400,  -16'sd1892,  16'sd1138,  16'sd1448, -16'sd1703, -16'sd784,   16'sd2009 },
        '{16'sd1448, -16'sd1138, -16'sd784,   16'sd2009, -16'sd1448, -16'sd400,   16'sd1892, -16'sd1703 },
        '{16'sd1448, -16'sd1703,  16'sd784,   16'sd400,  -16'sd1448,  16'sd2009, -16'sd1892,  16'sd1138 },
        '{16'sd1448, -16'sd2009,  16'sd1892, -16'sd1703,  16'sd1448, -16'sd1138,  16'sd784,  -16'sd400  }
    };

    typedef enum logic {
        S_LOAD,
        S_OUT
    } state_t;

    // Round half up, then arithmetic shift right by frac bits
    function automatic logic signed [63:0] round_frac(input logic signed [63:0] acc,
                                                      input int unsigned       frac);
        return (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    endfunction

    // Clamp a value to the signed range of a w-bit two's-complement number
    function automatic logic signed [63:0] sat(input logic signed [63:0] v,
                                               input int unsigned       w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        return v;
    endfunction

endpackage

// File: rtl/idct1d.sv
// Combinational 8-point 1-D inverse DCT with rounding and output saturation.
module idct1d
    import idct_pkg::*;
#(
    parameter int IN_W      = 20,
    parameter int OUT_W     = 20,
    parameter int COEF_FRAC = COEF_FRAC_DEF
) (
    input  logic [8*IN_W-1:0]  i_x,
    output logic [8*OUT_W-1:0] o_y
);

    logic signed [63:0] w_acc;

    // Full-width matrix-vector product per output, then round and clamp
    always_comb begin
        o_y   = '0;
        w_acc = '0;
        for (int unsigned n = 0; n < 8; n++) begin
            w_acc = '0;
            for (int unsigned k = 0; k < 8; k++) begin
                w_acc = w_acc + 64'($signed(i_x[k*IN_W +: IN_W])) * 64'(K_TAB[n][k]);
            end
            o_y[n*OUT_W +: OUT_W] = OUT_W'(sat(round_frac(w_acc, COEF_FRAC), OUT_W));
        end
    end

endmodule

// File: rtl/idct2d_stream.sv
// Streaming 2-D 8x8 inverse DCT: row pass into a transpose buffer, then a
// column pass emitted one column per handshake, sharing one 1-D datapath.
module idct2d_stream
    import idct_pkg::*;
#(
    parameter int N         = 16,
    parameter int COEF_FRAC = COEF_FRAC_DEF,
    parameter int IW        = N + 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [8*N-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [8*N-1:0] out_data
);

    state_t          r_state;
    logic [2:0]      r_row_cnt;
    logic [3:0]      r_col_cnt;
    logic            r_out_valid;
    logic [8*N-1:0]  r_out_data;
    logic [IW-1:0]   r_buf [8][8];

    logic [8*IW-1:0] w_idct_in;
    logic [8*IW-1:0] w_idct_out;
    logic [8*N-1:0]  w_col_out;
    logic            w_in_beat;
    logic            w_load_col;
    logic            w_last_out;

    assign in_ready   = (r_state == S_LOAD);
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign w_in_beat  = in_valid && in_ready;
    assign w_load_col = (r_state == S_OUT) && (r_col_cnt < 4'd8) && (!r_out_valid || out_ready);
    assign w_last_out = (r_state == S_OUT) && (r_col_cnt == 4'd8) && r_out_valid && out_ready;

    // Shared datapath operand: sign-extended coefficient row while loading, buffer column while emitting
    always_comb begin
        w_idct_in = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (r_state == S_LOAD)
                w_idct_in[i*IW +: IW] = IW'($signed(in_data[i*N +: N]));
            else
                w_idct_in[i*IW +: IW] = r_buf[i][r_col_cnt[2:0]];
        end
    end

    idct1d #(
        .IN_W      (IW),
        .OUT_W     (IW),
        .COEF_FRAC (COEF_FRAC)
    ) u_idct1d (
        .i_x (w_idct_in),
        .o_y (w_idct_out)
    );

    // Column results narrowed to N bits; clamping an IW-clamped value to N equals a direct clamp to N
    always_comb begin
        w_col_out = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            w_col_out[i*N +: N] = N'(sat(64'($signed(w_idct_out[i*IW +: IW])), N));
        end
    end

    // Row-pass results land in the transpose buffer; contents survive reset as don't-care
    always_ff @(posedge clk) begin
        if (rst_n && w_in_beat) begin
            for (int unsigned i = 0; i < 8; i++) begin
                r_buf[r_row_cnt][i] <= w_idct_out[i*IW +: IW];
            end
        end
    end

    // Block sequencing: count input rows, then emit columns with a held output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_LOAD;
            r_row_cnt   <= '0;
            r_col_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_in_beat) begin
                        if (r_row_cnt == 3'd7) begin
                            r_row_cnt <= '0;
                            r_state   <= S_OUT;
                        end else begin
                            r_row_cnt <= r_row_cnt + 3'd1;
                        end
                    end
                end
                S_OUT: begin
                    if (w_load_col) begin
                        r_out_data  <= w_col_out;
                        r_out_valid <= 1'b1;
                        r_col_cnt   <= r_col_cnt + 4'd1;
                    end else if (w_last_out) begin
                        r_out_valid <= 1'b0;
                        r_col_cnt   <= '0;
                        r_state     <= S_LOAD;
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_idct2d_stream.sv
// Directed bench for idct2d_stream with hand-computed column values.
module tb_idct2d_stream;

    localparam int N = 16;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic           in_valid  = 1'b0;
    logic           out_ready = 1'b0;
    logic [8*N-1:0] in_data   = '0;
    logic           in_ready;
    logic           out_valid;
    logic [8*N-1:0] out_data;

    int checks = 0;
    int errors = 0;

    logic [8*N-1:0] blk [0:7];
    logic [8*N-1:0] got [0:7];
    int             got_n;

    always #5 clk = ~clk;

    idct2d_stream #(
        .N         (N),
        .COEF_FRAC (12),
        .IW        (N + 4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    function automatic logic [8*N-1:0] fill(input int v);
        logic [8*N-1:0] r;
        for (int i = 0; i < 8; i++) r[i*N +: N] = N'(v);
        return r;
    endfunction

    function automatic logic [8*N-1:0] pack8(input int e0, input int e1, input int e2, input int e3,
                                             input int e4, input int e5, input int e6, input int e7);
        return {N'(e7), N'(e6), N'(e5), N'(e4), N'(e3), N'(e2), N'(e1), N'(e0)};
    endfunction

    // Drive one row; called away from the clock edge, returns #1 after the transfer edge
    task automatic send_row(input logic [8*N-1:0] d);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL send_row_wait: in_ready=%0b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_block(input int gap_after, input int gap_len);
        for (int r = 0; r < 8; r++) begin
            send_row(blk[r]);
            if (r == gap_after) begin
                repeat (gap_len) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic set_dc_block();
        for (int r = 0; r < 8; r++) blk[r] = '0;
        blk[0] = pack8(64, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Gather up to 8 output columns with out_ready high, bounded
    task automatic collect();
        int cyc;
        cyc   = 0;
        got_n = 0;
        while (got_n < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            out_ready = 1'b1;
            if (out_valid) begin
                got[got_n] = out_data;
                got_n++;
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h required 0", out_data); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_dc();
        out_ready = 1'b0;
        set_dc_block();
        send_block(-1, 0);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL dc_latency_early: out_valid=%0b required 0", out_valid); end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL dc_latency: out_valid=%0b required 1", out_valid); end
        collect();
        checks++;
        if (got_n !== 8) begin errors++; $display("FAIL dc_beats: got %0d required 8", got_n); end
        for (int c = 0; c < got_n; c++) begin
            checks++;
            if (got[c] !== fill(8)) begin errors++; $display("FAIL dc_col%0d: got %h required %h", c, got[c], fill(8)); end
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL dc_end: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int             lowcnt;
        int             beats;
        int             cyc;
        logic [8*N-1:0] acc;
        for (int r = 0; r < 8; r++) blk[r] = '0;
        out_ready = 1'b1;
        send_block(-1, 0);
        lowcnt = 0;
        beats  = 0;
        acc    = '0;
        cyc    = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (in_ready) break;
            lowcnt++;
            if (out_valid) begin
                beats++;
                acc = acc | out_data;
            end
        end
        checks++;
        if (lowcnt !== 9) begin errors++; $display("FAIL b2b_in_ready_low: got %0d cycles required 9", lowcnt); end
        checks++;
        if (beats !== 8) begin errors++; $display("FAIL b2b_beats1: got %0d required 8", beats); end
        checks++;
        if (acc !== '0) begin errors++; $display("FAIL b2b_data1: got %h required 0", acc); end
        out_ready = 1'b0;
        send_block(-1, 0);
        collect();
        checks++;
        if (got_n !== 8) begin errors++; $display("FAIL b2b_beats2: got %0d required 8", got_n); end
        for (int c = 0; c < got_n; c++) begin
            checks++;
            if (got[c] !== '0) begin errors++; $display("FAIL b2b_col%0d: got %h required 0", c, got[c]); end
        end
    endtask

    task automatic test_saturation();
        logic [N-1:0] e;
        out_ready = 1'b0;
        for (int r = 0; r < 8; r++) blk[r] = fill(32767);
        send_block(-1, 0);
        collect();
        checks++;
        if (got_n !== 8) begin errors++; $display("FAIL sat_beats: got %0d required 8", got_n); end
        e = got[0][0 +: N];
        checks++;
        if (e !== 16'h7FFF) begin errors++; $display("FAIL sat_c0r0: got %h required 7fff", e); end
        e = got[0][N +: N];
        checks++;
        if (e !== 16'h8000) begin errors++; $display("FAIL sat_c0r1: got %h required 8000", e); end
    endtask

    task automatic test_backpressure();
        int             cyc;
        logic [8*N-1:0] held;
        out_ready = 1'b0;
        set_dc_block();
        send_block(-1, 0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_rise: out_valid=%0b required 1", out_valid); end
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== fill(8) || out_data !== held) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%0b data=%h required 1/%h", i, out_valid, out_data, fill(8));
            end
        end
        collect();
        checks++;
        if (got_n !== 8) begin errors++; $display("FAIL bp_beats: got %0d required 8", got_n); end
        for (int c = 0; c < got_n; c++) begin
            checks++;
            if (got[c] !== fill(8)) begin errors++; $display("FAIL bp_col%0d: got %h required %h", c, got[c], fill(8)); end
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_end: in_ready=%0b required 1", in_ready); end
    endtask

    // Row 0 and row 4 carry DC=64: every column becomes [16,0,0,16,16,0,0,16]
    task automatic test_input_gaps();
        logic [8*N-1:0] exp_col;
        exp_col = pack8(16, 0, 0, 16, 16, 0, 0, 16);
        for (int pass = 0; pass < 2; pass++) begin
            out_ready = 1'b0;
            for (int r = 0; r < 8; r++) blk[r] = '0;
            blk[0] = pack8(64, 0, 0, 0, 0, 0, 0, 0);
            blk[4] = pack8(64, 0, 0, 0, 0, 0, 0, 0);
            if (pass == 0) send_block(-1, 0);
            else           send_block(3, 3);
            collect();
            checks++;
            if (got_n !== 8) begin errors++; $display("FAIL gap%0d_beats: got %0d required 8", pass, got_n); end
            for (int c = 0; c < got_n; c++) begin
                checks++;
                if (got[c] !== exp_col) begin
                    errors++;
                    $display("FAIL gap%0d_col%0d: got %h required %h", pass, c, got[c], exp_col);
                end
            end
        end
    endtask

    task automatic test_reset_mid_output();
        int cyc;
        out_ready = 1'b0;
        set_dc_block();
        send_block(-1, 0);
        got_n = 0;
        cyc   = 0;
        while (got_n < 3 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            out_ready = 1'b1;
            if (out_valid) got_n++;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = fill(1000);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %0b required 0", out_valid); end
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL rmid_out_data: got %h required 0", out_data); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %0b required 1", in_ready); end
        @(posedge clk); #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        set_dc_block();
        send_block(-1, 0);
        collect();
        checks++;
        if (got_n !== 8) begin errors++; $display("FAIL rmid_beats: got %0d required 8", got_n); end
        for (int c = 0; c < got_n; c++) begin
            checks++;
            if (got[c] !== fill(8)) begin errors++; $display("FAIL rmid_col%0d: got %h required %h", c, got[c], fill(8)); end
        end
    endtask

    initial begin
        test_reset();
        test_dc();
        test_back_to_back();
        test_saturation();
        test_backpressure();
        test_input_gaps();
        test_reset_mid_output();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
